iommu_ptw_ls_initiator: RTL
===========================

# iommu_ptw_ls_initiator

Requester-side front end of the IOMMU walker load/store port. Up to MAX_PW walker contexts present memory requests to this block. It arbitrates among them round-robin and tags each request with the winning context index. It issues the winner on the shared load/store port using the four-phase irdy/trdy request handshake, then accepts tagged load/AMO data returns through the matching four-phase return handshake and routes each return to its context.

## Interface
- MAX_PW, 4, number of walker contexts; tag width TW = $clog2(MAX_PW), minimum 1
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- c_req_valid_i  in  MAX_PW  per-context request valid, level, held until c_req_ready_o
- c_req_ready_o  out  MAX_PW  one-cycle accept pulse, at most one bit set
- c_req_addr_i  in  46*MAX_PW  per-context address; context i uses bits [46i+45:46i]
- c_req_op_i  in  2*MAX_PW  per-context op (LOAD, STORE, AMO from the shared constants header)
- c_req_size_i  in  7*MAX_PW  per-context size
- c_rsp_valid_o  out  MAX_PW  one-cycle response pulse to the tagged context
- c_rsp_data_o  out  512  response data, valid with c_rsp_valid_o
- c_rsp_acc_fault_o  out  1  access fault, valid with c_rsp_valid_o
- c_rsp_poison_o  out  1  poison, valid with c_rsp_valid_o
- ls_addr_o, ls_op_o, ls_tag_o, ls_size_o  out  46/2/TW/7  request fields, stable while ls_req_irdy_o=1
- ls_req_irdy_o  out  1  request initiator-ready
- ls_req_trdy_i  in  1  request target-ready
- ld_data_i, ld_acc_fault_i, ld_poison_i, ld_tag_i  in  512/1/1/TW  return fields
- ld_data_irdy_i  in  1  return initiator-ready
- ld_data_trdy_o  out  1  return target-ready
- unexp_rsp_o  out  1  sticky flag: a return arrived for a tag with no outstanding request

## Operation
- outstanding[MAX_PW]: set at acceptance of a LOAD/AMO, cleared when its data return is captured. STORE is posted and never sets the bit.
- Eligible context: c_req_valid_i[i] & ~outstanding[i].
- Round-robin pointer rr: search starts at rr; after a grant to i, rr <= (i+1) mod MAX_PW.
- Request FSM:
  - Q_IDLE: if any eligible context, grant the winner. Pulse c_req_ready_o[winner], latch addr/op/size, set tag=winner, set outstanding for LOAD/AMO, go to Q_REQ.
  - Q_REQ: ls_req_irdy_o=1. When ls_req_trdy_i=1, go to Q_REL.
  - Q_REL: ls_req_irdy_o=0. When ls_req_trdy_i=0, go to Q_IDLE.
- Return FSM, independent of the request FSM:
  - R_IDLE: when ld_data_irdy_i=1, capture data/fault/poison/tag, drive ld_data_trdy_o=1, go to R_REL.
    - If outstanding[tag] is set: pulse c_rsp_valid_o[tag] and clear outstanding[tag].
    - Otherwise: set unexp_rsp_o and emit no pulse.
  - R_REL: when ld_data_irdy_i=0, drive ld_data_trdy_o=0 and go to R_IDLE.
- Simultaneous grant and return in one cycle, same context: the clear has priority over the set. This case is impossible anyway, because the context is ineligible while its bit is set.
- A return may arrive while the request FSM is in any state.
- c_rsp_data_o and the fault/poison outputs hold their last captured value between pulses.

## Timing
- Reset values: all outputs 0; rr=0; outstanding=0; unexp_rsp_o=0; both FSMs idle. Asserting rst mid-handshake aborts it, and irdy/trdy drop asynchronously.
- Request path:
  - Grant pulse in cycle T; ls_req_irdy_o=1 from T+1.
  - trdy sampled high in cycle U drops irdy at U+1.
  - trdy sampled low in Q_REL returns to Q_IDLE next cycle, so the next grant comes one cycle later.
  - Minimum issue interval is 4 cycles with a zero-wait target.
- Return path:
  - irdy sampled high in cycle V gives ld_data_trdy_o=1 and c_rsp_valid_o pulse in V+1.
  - irdy sampled low in R_REL drops trdy the following cycle.
- Registered outputs only; no combinational path from any input to any output.

## Test plan
- Reset then single LOAD: context 0 requests addr 46'h1000. Required: ready pulse; irdy with tag 0 and addr 46'h1000; full four-phase completion. Return data 512'h2001 tag 0 → c_rsp_valid_o=4'b0001 with data 512'h2001.
- Round-robin fairness: all four contexts issue STOREs continuously. Required grant order 0,1,2,3,0,…, and no outstanding bits are ever set.
- Out-of-order returns: LOADs from contexts 1 and 2 issued in that order; returns for tag 2 then tag 1 with data 512'h3001 / 512'h4001. Each must be routed to the correct context, and outstanding ends at 0.
- Blocking: context 3 has a LOAD outstanding and re-asserts valid. Required: no ready pulse for 3 until its return is captured, while context 0 is still granted.
- Unexpected return: return with tag 1 when nothing is outstanding. Required: handshake completes, no c_rsp_valid_o pulse, unexp_rsp_o=1 sticky until reset.
- Reset mid-operation: assert rst while in Q_REQ and R_REL. Required: ls_req_irdy_o, ld_data_trdy_o and outstanding are immediately 0; normal traffic resumes after deassertion.

Source files
------------

// File: rtl/iommu_ptw_ls_initiator.sv
// iommu_ptw_ls_initiator: requester-side front end of the IOMMU walker
// load/store port.
//
// Round-robin arbitration among MAX_PW walker contexts. The winner is issued
// on the shared port with a four-phase irdy/trdy handshake and tagged with
// its context index. Tagged load/AMO returns come back through a matching
// four-phase handshake and are routed to the owning context.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   c_req_valid_i/ready_o     per-context request handshake (ready = 1-cycle pulse)
//   c_req_addr/op/size_i      per-context request fields, packed by context
//   c_rsp_valid_o             per-context 1-cycle response pulse
//   c_rsp_data/acc_fault/poison_o  last captured return fields
//   ls_addr/op/tag/size_o     issued request, stable while ls_req_irdy_o
//   ls_req_irdy_o/trdy_i      request four-phase handshake
//   ld_data/acc_fault/poison/tag_i  return fields
//   ld_data_irdy_i/trdy_o     return four-phase handshake
//   unexp_rsp_o               sticky: return for a tag with nothing outstanding
module iommu_ptw_ls_initiator #(
    parameter int MAX_PW = 4,
    localparam int TW = (MAX_PW > 1) ? $clog2(MAX_PW) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MAX_PW-1:0]     c_req_valid_i,
    output logic [MAX_PW-1:0]     c_req_ready_o,
    input  logic [46*MAX_PW-1:0]  c_req_addr_i,
    input  logic [2*MAX_PW-1:0]   c_req_op_i,
    input  logic [7*MAX_PW-1:0]   c_req_size_i,
    output logic [MAX_PW-1:0]     c_rsp_valid_o,
    output logic [511:0]          c_rsp_data_o,
    output logic                  c_rsp_acc_fault_o,
    output logic                  c_rsp_poison_o,
    output logic [45:0]           ls_addr_o,
    output logic [1:0]            ls_op_o,
    output logic [TW-1:0]         ls_tag_o,
    output logic [6:0]            ls_size_o,
    output logic                  ls_req_irdy_o,
    input  logic                  ls_req_trdy_i,
    input  logic [511:0]          ld_data_i,
    input  logic                  ld_acc_fault_i,
    input  logic                  ld_poison_i,
    input  logic [TW-1:0]         ld_tag_i,
    input  logic                  ld_data_irdy_i,
    output logic                  ld_data_trdy_o,
    output logic                  unexp_rsp_o
);

    // Op encoding: LOAD=0, STORE=1, AMO=2. Only STORE is special here.
    localparam logic [1:0] OP_STORE = 2'd1;
    localparam int NT = 2 ** TW;

    typedef enum logic [1:0] {Q_IDLE, Q_REQ, Q_REL} q_state_t;
    typedef enum logic {R_IDLE, R_REL} r_state_t;

    q_state_t q_state, q_nxt;
    r_state_t r_state, r_nxt;

    logic [45:0] addr_a [MAX_PW];
    logic [1:0]  op_a   [MAX_PW];
    logic [6:0]  size_a [MAX_PW];

    for (genvar g = 0; g < MAX_PW; g++) begin : g_unpack
        assign addr_a[g] = c_req_addr_i[46*g +: 46];
        assign op_a[g]   = c_req_op_i[2*g +: 2];
        assign size_a[g] = c_req_size_i[7*g +: 7];
    end

    logic [MAX_PW-1:0] outstanding;
    logic [MAX_PW-1:0] elig;
    logic [MAX_PW-1:0] set_mask;
    logic [MAX_PW-1:0] clr_mask;
    logic [NT-1:0]     out_pad;
    logic [TW-1:0]     rr;
    logic [TW-1:0]     win;
    logic [TW-1:0]     idx;
    int                cand;
    logic              found;
    logic              grant;
    logic              irdy_nxt;
    logic              cap;
    logic              hit;
    logic              trdy_nxt;

    assign elig = c_req_valid_i & ~outstanding;

    // First eligible context at or after rr, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        cand  = 0;
        for (int k = 0; k < MAX_PW; k++) begin
            cand = int'(rr) + k;
            if (cand >= MAX_PW) cand = cand - MAX_PW;
            idx = TW'(cand);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Request FSM. irdy rises the cycle after the grant pulse, so Q_REQ
    // only waits for trdy once its own irdy is visible.
    always_comb begin
        q_nxt    = q_state;
        grant    = 1'b0;
        irdy_nxt = 1'b0;
        unique case (q_state)
            Q_IDLE: begin
                if (found) begin
                    grant = 1'b1;
                    q_nxt = Q_REQ;
                end
            end
            Q_REQ: begin
                if (ls_req_irdy_o && ls_req_trdy_i) q_nxt = Q_REL;
                else irdy_nxt = 1'b1;
            end
            Q_REL: begin
                if (!ls_req_trdy_i) q_nxt = Q_IDLE;
            end
            default: q_nxt = Q_IDLE;
        endcase
    end

    assign set_mask = (grant && op_a[win] != OP_STORE)
                      ? (MAX_PW'(1) << win) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_state       <= Q_IDLE;
            rr            <= '0;
            c_req_ready_o <= '0;
            ls_req_irdy_o <= 1'b0;
            ls_addr_o     <= '0;
            ls_op_o       <= '0;
            ls_tag_o      <= '0;
            ls_size_o     <= '0;
        end else begin
            q_state       <= q_nxt;
            ls_req_irdy_o <= irdy_nxt;
            c_req_ready_o <= '0;
            if (grant) begin
                c_req_ready_o <= MAX_PW'(1) << win;
                ls_addr_o     <= addr_a[win];
                ls_op_o       <= op_a[win];
                ls_size_o     <= size_a[win];
                ls_tag_o      <= win;
                rr <= (win == TW'(MAX_PW - 1)) ? '0 : win + 1'b1;
            end
        end
    end

    // Return FSM, independent of the request side.
    always_comb begin
        r_nxt    = r_state;
        cap      = 1'b0;
        trdy_nxt = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                if (ld_data_irdy_i) begin
                    cap      = 1'b1;
                    trdy_nxt = 1'b1;
                    r_nxt    = R_REL;
                end
            end
            R_REL: begin
                if (ld_data_irdy_i) trdy_nxt = 1'b1;
                else r_nxt = R_IDLE;
            end
            default: r_nxt = R_IDLE;
        endcase
    end

    // Padding lets an out-of-range tag (non power-of-two MAX_PW) read as
    // not outstanding instead of indexing past the vector.
    assign out_pad  = NT'(outstanding);
    assign hit      = cap && out_pad[ld_tag_i];
    assign clr_mask = hit ? (MAX_PW'(1) << ld_tag_i) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state           <= R_IDLE;
            ld_data_trdy_o    <= 1'b0;
            c_rsp_valid_o     <= '0;
            c_rsp_data_o      <= '0;
            c_rsp_acc_fault_o <= 1'b0;
            c_rsp_poison_o    <= 1'b0;
            unexp_rsp_o       <= 1'b0;
        end else begin
            r_state        <= r_nxt;
            ld_data_trdy_o <= trdy_nxt;
            c_rsp_valid_o  <= clr_mask;
            if (cap) begin
                c_rsp_data_o      <= ld_data_i;
                c_rsp_acc_fault_o <= ld_acc_fault_i;
                c_rsp_poison_o    <= ld_poison_i;
            end
            if (cap && !hit) unexp_rsp_o <= 1'b1;
        end
    end

    // Clear wins over set for the same context in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) outstanding <= '0;
        else outstanding <= (outstanding | set_mask) & ~clr_mask;
    end

endmodule
